multicycle_ctrl: RTL



---
 rtl/multicycle_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the 32-bit multi-cycle MIPS-subset CPU.
// Sequences fetch/decode/execute/memory/writeback and drives every datapath enable and select.
module multicycle_ctrl #(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [OP_W-1:0] Op,
    input  logic            Zero,
    input  logic            MemReady,
    output logic            PCEn,
    output logic [1:0]      PCSrc,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            RegDst,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic            IllegalOp,
    output logic [ST_W-1:0] State
);

    localparam logic [ST_W-1:0] S_FETCH   = ST_W'(0);
    localparam logic [ST_W-1:0] S_DECODE  = ST_W'(1);
    localparam logic [ST_W-1:0] S_MEMADR  = ST_W'(2);
    localparam logic [ST_W-1:0] S_MEMRD   = ST_W'(3);
    localparam logic [ST_W-1:0] S_MEMWB   = ST_W'(4);
    localparam logic [ST_W-1:0] S_MEMWR   = ST_W'(5);
    localparam logic [ST_W-1:0] S_EXEC    = ST_W'(6);
    localparam logic [ST_W-1:0] S_ALUWB   = ST_W'(7);
    localparam logic [ST_W-1:0] S_BRANCH  = ST_W'(8);
    localparam logic [ST_W-1:0] S_ADDI_EX = ST_W'(9);
    localparam logic [ST_W-1:0] S_ADDI_WB = ST_W'(10);
    localparam logic [ST_W-1:0] S_JUMP    = ST_W'(11);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

    logic [ST_W-1:0] state_r;
    logic [ST_W-1:0] next_state_s;

    function automatic logic op_known(input logic [OP_W-1:0] op);
        logic known;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: known = 1'b1;
            default:                                              known = 1'b0;
        endcase
        return known;
    endfunction

    // State register; reset wins over any transition, including a memory stall.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH:   next_state_s = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW:   next_state_s = S_MEMADR;
                    OP_RTYPE:       next_state_s = S_EXEC;
                    OP_BEQ, OP_BNE: next_state_s = S_BRANCH;
                    OP_ADDI:        next_state_s = S_ADDI_EX;
                    OP_J:           next_state_s = S_JUMP;
                    default:        next_state_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (Op == OP_LW) begin
                    next_state_s = S_MEMRD;
                end else if (Op == OP_SW) begin
                    next_state_s = S_MEMWR;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_MEMRD:   next_state_s = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:   next_state_s = S_FETCH;
            S_MEMWR:   next_state_s = MemReady ? S_FETCH : S_MEMWR;
            S_EXEC:    next_state_s = S_ALUWB;
            S_ALUWB:   next_state_s = S_FETCH;
            S_BRANCH:  next_state_s = S_FETCH;
            S_ADDI_EX: next_state_s = S_ADDI_WB;
            S_ADDI_WB: next_state_s = S_FETCH;
            S_JUMP:    next_state_s = S_FETCH;
            default:   next_state_s = S_FETCH;
        endcase
    end

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        PCEn      = 1'b0;
        PCSrc     = 2'b00;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        IllegalOp = 1'b0;
        State     = state_r;
        if (reset) begin
            case (state_r)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCEn    = MemReady;
                end
                S_DECODE: begin
                    ALUSrcB   = 2'b11;
                    IllegalOp = ~op_known(Op);
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b01;
                    PCSrc   = 2'b01;
                    PCEn    = (Op == OP_BNE) ? ~Zero : Zero;
                end
                S_ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_ADDI_WB: begin
                    RegWrite = 1'b1;
                end
                S_JUMP: begin
                    PCSrc = 2'b10;
                    PCEn  = 1'b1;
                end
                default: begin
                    PCEn = 1'b0;
                end
            endcase
        end else begin
            State = {ST_W{1'b0}};
        end
    end

endmodule
